// File: rtl/vector_scale_mc.sv
// vector_scale_mc: element-serial Mersenne-31 scale / axpy, one result element per cycle
module vector_scale_mc #(
   parameter int WORD_WIDTH = 31,
   parameter int VECTOR_SIZE = 16
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic                                   accumulate,
   input  logic [WORD_WIDTH-1:0]                  scalar,
   input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec_x,
   input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec_y,
   output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] result,
   output logic                                   busy,
   output logic                                   done
);
   localparam int W = WORD_WIDTH;
   localparam int FW = 2 * W + 1;
   localparam int IW = $clog2(VECTOR_SIZE);
   localparam logic [W-1:0] P = {W{1'b1}};
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_next;
   logic [IW-1:0] index;
   logic [W-1:0] a;
   logic acc;
   logic last;
   logic [FW-1:0] full;
   // Fold high bits onto low bits (2^W == 1 mod p) until the value fits, then map p to 0.
   function automatic logic [W-1:0] m31_reduce(input logic [FW-1:0] v);
      logic [W+1:0] f1;
      logic [W:0] f2;
      logic [W-1:0] f3;
      f1 = (W+2)'(v[W-1:0]) + (W+2)'(v[FW-1:W]);
      f2 = (W+1)'(f1[W-1:0]) + (W+1)'(f1[W+1:W]);
      f3 = f2[W-1:0] + W'(f2[W]);
      return f3 == P ? '0 : f3;
   endfunction
   assign last = index == IW'(VECTOR_SIZE - 1);
   assign full = FW'(a) * FW'(vec_x[index]) + (acc ? FW'(vec_y[index]) : '0);
   always_comb begin
      state_next = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
      busy = state == RUN;
      done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         index <= '0;
         a <= '0;
         acc <= 1'b0;
         result <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            a <= scalar;
            acc <= accumulate;
            index <= '0;
         end
         if (state == RUN) begin
            result[index] <= m31_reduce(full);
            index <= last ? '0 : index + 1'b1;
         end
      end
   end
endmodule
